// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: shared polarity codes and arbiter state type for edge_event_arbiter.
// Rev 1.0
`default_nettype none

package edge_arb_pkg;

  localparam logic POL_RISE = 1'b1;
  localparam logic POL_FALL = 1'b0;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/edge_capture.sv
// edge_capture: per-channel edge detect, depth-1 pending slot and sticky overflow flag.
// Rev 1.0
`default_nettype none

module edge_capture
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic pe_en,
  input  logic ne_en,
  input  logic grant,
  input  logic ovf_clr,
  output logic pend_valid,
  output logic pend_pol,
  output logic overflow
);

  logic sig_dly;
  logic rise;
  logic fall;
  logic edge_hit;

  assign rise     = sig & ~sig_dly & pe_en;
  assign fall     = ~sig & sig_dly & ne_en;
  assign edge_hit = rise | fall;

  always_ff @(posedge clk) begin
    // The delay flop follows sig during reset so release never looks like an edge.
    sig_dly <= sig;
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_pol   <= POL_FALL;
      overflow   <= 1'b0;
    end else begin
      if (edge_hit && (!pend_valid || grant)) begin
        pend_valid <= 1'b1;
        pend_pol   <= rise ? POL_RISE : POL_FALL;
      end else if (grant) begin
        pend_valid <= 1'b0;
      end

      if (edge_hit && pend_valid && !grant) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: N edge-capture channels serialised onto one valid/ready port, round-robin.
// Rev 1.0
`default_nettype none

module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sig,
  input  logic [N-1:0]   pe_en,
  input  logic [N-1:0]   ne_en,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_pol,
  output logic [N-1:0]   overflow,
  input  logic           ovf_clr
);

  logic [N-1:0]   pend_valid;
  logic [N-1:0]   pend_pol;
  logic [N-1:0]   grant;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           any_pend;
  logic           do_grant;
  arb_state_t     state;
  arb_state_t     state_nxt;

  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_capture u_cap (
      .clk        (clk),
      .rst        (rst),
      .sig        (sig[i]),
      .pe_en      (pe_en[i]),
      .ne_en      (ne_en[i]),
      .grant      (grant[i]),
      .ovf_clr    (ovf_clr),
      .pend_valid (pend_valid[i]),
      .pend_pol   (pend_pol[i]),
      .overflow   (overflow[i])
    );
  end

  // First pending channel at or above rr_ptr, wrapping past N-1 back to 0.
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    winner   = '0;
    any_pend = |pend_valid;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && pend_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          do_grant  = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          if (any_pend) begin
            do_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (do_grant) begin
      grant[winner] = 1'b1;
    end
  end

  assign evt_valid = (state == PRESENT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      evt_id  <= '0;
      evt_pol <= POL_FALL;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        rr_ptr  <= (int'(winner) == N - 1) ? '0 : winner + 1'b1;
        evt_id  <= winner;
        evt_pol <= pend_pol[winner];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed scenarios plus randomized run against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   sig = '0;
  logic [N-1:0]   pe_en = '0;
  logic [N-1:0]   ne_en = '0;
  logic           evt_ready = 1'b0;
  logic           ovf_clr = 1'b0;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_pol;
  logic [N-1:0]   overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .pe_en     (pe_en),
    .ne_en     (ne_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_pol   (evt_pol),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // Reference model: one pending slot per channel, an output slot, and a rotating start index.
  bit m_prev [N];
  bit m_pend [N];
  bit m_ppol [N];
  bit m_ovf  [N];
  int m_ptr = 0;
  bit m_valid = 0;
  int m_id = 0;
  bit m_pol = 0;
  int m_win;
  bit m_rise;
  bit m_evt;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = sig[i];
        m_pend[i] = 0;
        m_ovf[i]  = 0;
      end
      m_ptr = 0; m_valid = 0; m_id = 0; m_pol = 0;
    end else begin
      m_win = -1;
      if (!m_valid || evt_ready)
        for (int k = 0; k < N; k++)
          if (m_win < 0 && m_pend[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
      if (m_valid && evt_ready) m_valid = 0;
      if (m_win >= 0) begin
        m_valid = 1;
        m_id    = m_win;
        m_pol   = m_ppol[m_win];
        m_pend[m_win] = 0;
        m_ptr   = (m_win + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        m_rise = sig[i] && !m_prev[i] && pe_en[i];
        m_evt  = m_rise || (!sig[i] && m_prev[i] && ne_en[i]);
        if (m_evt && m_pend[i]) m_ovf[i] = 1;
        else if (ovf_clr) m_ovf[i] = 0;
        if (m_evt && !m_pend[i]) begin
          m_pend[i] = 1;
          m_ppol[i] = m_rise;
        end
        m_prev[i] = sig[i];
      end
    end
  end

  function automatic logic [N-1:0] model_ovf();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] s);
    rst = 1'b0; sig = s; ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; evt_ready = 1'b1; pe_en = '1; ne_en = '1;
    for (int c = 0; c < 4; c++) begin
      sig = N'($urandom);
      tick();
      checks++;
      if (evt_valid !== 1'b0 || overflow !== '0 || evt_id !== '0 || evt_pol !== 1'b0) begin
        errors++;
        $display("FAIL reset: valid=%b ovf=%b id=%0d pol=%b, want 0/0/0/0", evt_valid, overflow, evt_id, evt_pol);
      end
    end
  endtask

  task automatic test_single_edge();
    do_reset('0);
    pe_en = '1; ne_en = '1; evt_ready = 1'b1;
    tick();
    sig[2] = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: valid=%b want 0", evt_valid);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_pol !== 1'b1) begin
      errors++; $display("FAIL single_event: valid=%b id=%0d pol=%b want 1/2/1", evt_valid, evt_id, evt_pol);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL single_oneshot: valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_reset_high();
    pe_en = '1; ne_en = '1; evt_ready = 1'b1;
    do_reset('1);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        errors++; $display("FAIL reset_high_quiet: cycle %0d valid=%b want 0", c, evt_valid);
      end
    end
    pe_en = '0; ne_en = 4'h1;
    sig[0] = 1'b0;
    tick(); tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_pol !== 1'b0) begin
      errors++; $display("FAIL reset_high_fall: valid=%b id=%0d pol=%b want 1/0/0", evt_valid, evt_id, evt_pol);
    end
  endtask

  task automatic test_fairness();
    int got[$];
    do_reset('0);
    pe_en = '1; ne_en = '0; evt_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      got.delete();
      sig = '1;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (evt_valid === 1'b1) got.push_back(int'(evt_id));
      end
      checks++;
      if (got.size() != N) begin
        errors++; $display("FAIL fairness_count: rep %0d got %0d events want %0d", rep, got.size(), N);
      end
      for (int k = 0; k < N && k < got.size(); k++) begin
        checks++;
        if (got[k] != k) begin
          errors++; $display("FAIL fairness_order: rep %0d slot %0d id=%0d want %0d", rep, k, got[k], k);
        end
      end
      sig = '0;
      tick(); tick(); tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset('0);
    pe_en = '1; ne_en = '1; evt_ready = 1'b0;
    sig[1] = 1'b1;
    tick(); tick();
    sig[1] = 1'b0;
    tick();
    sig[1] = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_pol !== 1'b1 || overflow !== 4'b0010) begin
      errors++; $display("FAIL bp_hold: valid=%b id=%0d pol=%b ovf=%b want 1/1/1/0010", evt_valid, evt_id, evt_pol, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 4'b0000 || evt_id !== 2'd1 || evt_pol !== 1'b1) begin
      errors++; $display("FAIL bp_clear: ovf=%b id=%0d pol=%b want 0000/1/1", overflow, evt_id, evt_pol);
    end
    evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_pol !== 1'b0) begin
      errors++; $display("FAIL bp_pending_fall: valid=%b id=%0d pol=%b want 1/1/0", evt_valid, evt_id, evt_pol);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_same_cycle();
    do_reset('0);
    pe_en = '1; ne_en = '1; evt_ready = 1'b0;
    sig[3] = 1'b1;
    tick(); tick();
    sig[3] = 1'b0;
    tick();
    sig[3] = 1'b1; evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_pol !== 1'b0 || overflow[3] !== 1'b0) begin
      errors++; $display("FAIL same_cycle_grant: valid=%b id=%0d pol=%b ovf3=%b want 1/3/0/0", evt_valid, evt_id, evt_pol, overflow[3]);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_pol !== 1'b1 || overflow[3] !== 1'b0) begin
      errors++; $display("FAIL same_cycle_capture: valid=%b id=%0d pol=%b ovf3=%b want 1/3/1/0", evt_valid, evt_id, evt_pol, overflow[3]);
    end
    tick();
  endtask

  task automatic test_masking();
    do_reset('0);
    pe_en = '0; ne_en = '0;
    for (int c = 0; c < 50; c++) begin
      sig = N'($urandom);
      evt_ready = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (evt_valid !== 1'b0 || m_valid !== 1'b0) begin
        errors++; $display("FAIL masking: cycle %0d valid=%b model=%b want 0", c, evt_valid, m_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset('0);
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 59) != 0);
      sig       = N'($urandom);
      pe_en     = N'($urandom);
      ne_en     = N'($urandom);
      evt_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (evt_valid !== m_valid || evt_id !== IDW'(m_id) || evt_pol !== m_pol || overflow !== model_ovf()) begin
        errors++;
        $display("FAIL random: cycle %0d dut v/id/pol/ovf=%b/%0d/%b/%b model=%b/%0d/%b/%b",
                 c, evt_valid, evt_id, evt_pol, overflow, m_valid, m_id, m_pol, model_ovf());
      end
    end
    rst = 1'b1; ovf_clr = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_single_edge();
    test_reset_high();
    test_fairness();
    test_backpressure();
    test_same_cycle();
    test_masking();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Collects rising/falling edge events from N synchronous input signals, queues one pending event per channel, and serialises them onto a single valid/ready event port with round-robin fairness. It sits between the per-signal edge detectors and the downstream event consumer (interrupt/status logic) so several monitored signals share one event path. Lost events are reported per channel through sticky overflow flags.

## Interface
- `N`, 4: number of monitored channels, legal 2..8
- `IDW`, $clog2(N): width of channel id
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `sig`  in  N  monitored signals, already synchronous to `clk`
- `pe_en`  in  N  per-channel rising-edge enable
- `ne_en`  in  N  per-channel falling-edge enable
- `evt_valid`  out  1  event presented
- `evt_ready`  in  1  consumer accepts event
- `evt_id`  out  IDW  channel of presented event
- `evt_pol`  out  1  1 = rising, 0 = falling
- `overflow`  out  N  sticky per-channel lost-event flag
- `ovf_clr`  in  1  clears all `overflow` bits

## Operation
- Per channel: `sig_dly` flop. Rising = `sig & ~sig_dly & pe_en`; falling = `~sig & sig_dly & ne_en`. At most one per channel per cycle.
- Reset (`rst`=0): `sig_dly <= sig`, so no spurious edge on release. `pend_valid`=0, `overflow`=0, `rr_ptr`=0, state IDLE, `evt_valid`=0, `evt_id`=0, `evt_pol`=0.
- Pending slot per channel (`pend_valid`, `pend_pol`), depth 1.
  - Detected edge with slot empty, or slot granted this same cycle: slot loads the new event.
  - Detected edge with slot full and not granted this cycle: event dropped, `overflow[i]` set.
- `ovf_clr` clears all bits; same-cycle set on a channel wins over clear.
- Changing `pe_en`/`ne_en` does not affect events already pending.
- Arbiter: winner is the first channel with `pend_valid` searching from `rr_ptr` upward, wrapping at N-1 to 0. On grant: `rr_ptr <= (winner+1) mod N`. The winner's slot clears and its event loads into the output register.
- FSM:
  - IDLE: `evt_valid`=0. If any pending, grant and go to PRESENT.
  - PRESENT: `evt_valid`=1, `evt_id`/`evt_pol` held stable until `evt_valid & evt_ready`. On handshake with any pending, grant the next event in the same cycle and stay in PRESENT. On handshake with none pending, go to IDLE.
  - No grant while PRESENT without a handshake.
- `evt_valid` never drops without a handshake, except on reset.

## Timing
- Edge sampled at clock edge t (the `sig` value differs from `sig_dly`): pending set at t. If IDLE, `evt_valid`=1 after edge t+1. Latency is 2 cycles, sample to valid.
- Back-to-back: with events pending, one event is transferred per cycle while `evt_ready`=1.
- With `evt_ready` tied high, N simultaneous edges drain in N consecutive cycles, in order `rr_ptr`, `rr_ptr`+1, ….
- A new edge on the channel being granted in the same cycle is captured, not counted as overflow.
- Reset mid-handshake: the event in flight and all pending events are discarded; `evt_valid`=0 on the next cycle.

## Structure
- Package `edge_arb_pkg`:
  - `POL_RISE`=1'b1, `POL_FALL`=1'b0
  - `arb_state_t` enum {IDLE, PRESENT}
- Sub-module `edge_capture`, one per channel. It holds the delay flop, enabled detect, pending slot and overflow flag. Inputs: `grant`, `ovf_clr`. Outputs: `pend_valid`, `pend_pol`, `overflow`.
- Top module: N `edge_capture` instances, round-robin priority search, FSM, output register.

## Test plan
- Single edge: after reset, `sig[2]` 0→1 with `pe_en`=4'hF and `evt_ready`=1 → 2 cycles later `evt_valid`=1, `evt_id`=2, `evt_pol`=1 for one cycle.
- Reset-high input: `sig`=4'hF held through reset release → no event for 10 cycles. Then `sig[0]` 1→0 with `ne_en[0]`=1 → event `id`=0, `pol`=0.
- Fairness: all four rise in the same cycle, `rr_ptr`=0, `evt_ready`=1 → ids 0,1,2,3 on consecutive cycles. Repeat the rise → ids 0,1,2,3 again (ptr wrapped to 0).
- Backpressure and overflow: `evt_ready`=0, `sig[1]` toggles 0→1→0→1 → `evt_id`/`evt_pol` stay stable (id 1, pol 1), `pend` holds the falling edge, 2nd rise sets `overflow[1]`=1. Then `ovf_clr` → `overflow`=0.
- Same-cycle grant and capture: the channel-3 event is being handed over while a new edge on channel 3 arrives → the new event is delivered next, `overflow[3]` stays 0.
- Masking: `pe_en`=0, `ne_en`=0, random `sig` for 50 cycles → `evt_valid` stays 0.
